// File: rtl/xt_uop_seq.sv
// Macro-instruction to micro-op sequencer: expands JSR/BSR/RET-style macros into
// fixed micro-op sequences with registered outputs and one cycle of latency.

`ifndef SR_IDX_SSP
`define SR_IDX_SSP 2'd2
`endif
`ifndef SR_IDX_LR
`define SR_IDX_LR 2'd1
`endif
`ifndef SR_IDX_PC
`define SR_IDX_PC 2'd3
`endif

module xt_uop_seq #(
  parameter int P_OPC_W    = 8,
  parameter int P_DATA_W   = 24,
  parameter int P_ADDR_W   = 48,
  parameter int P_SSP_STEP = 2,
  parameter int P_RET_ADJ  = 1,
  parameter bit P_EN_KRET  = 1'b1
) (
  input  logic                iw_clk,
  input  logic                iw_rst,
  input  logic [P_ADDR_W-1:0] iw_pc,
  input  logic [P_DATA_W-1:0] iw_instr,
  input  logic                iw_stall,
  input  logic                iw_flush,
  output logic [P_ADDR_W-1:0] ow_pc,
  output logic [P_DATA_W-1:0] ow_instr,
  output logic                ow_busy,
  output logic [1:0]          ow_uop_idx,
  output logic                ow_uop_last
);

  if (P_DATA_W != P_OPC_W + 16) begin : g_bad_width
    $fatal(1, "xt_uop_seq: P_DATA_W must equal P_OPC_W+16");
  end

  localparam logic [P_OPC_W-1:0] OPC_NOP      = P_OPC_W'(8'h00);
  localparam logic [P_OPC_W-1:0] OPC_JSRUI    = P_OPC_W'(8'h10);
  localparam logic [P_OPC_W-1:0] OPC_BSRSR    = P_OPC_W'(8'h11);
  localparam logic [P_OPC_W-1:0] OPC_BSRSO    = P_OPC_W'(8'h12);
  localparam logic [P_OPC_W-1:0] OPC_RET      = P_OPC_W'(8'h13);
  localparam logic [P_OPC_W-1:0] OPC_KRET     = P_OPC_W'(8'h14);
  localparam logic [P_OPC_W-1:0] OPC_SETSSP   = P_OPC_W'(8'h15);
  localparam logic [P_OPC_W-1:0] OPC_BTP      = P_OPC_W'(8'h16);
  localparam logic [P_OPC_W-1:0] OPC_SRSUBSI  = P_OPC_W'(8'h20);
  localparam logic [P_OPC_W-1:0] OPC_SRSTSO   = P_OPC_W'(8'h21);
  localparam logic [P_OPC_W-1:0] OPC_SRMOVUR  = P_OPC_W'(8'h22);
  localparam logic [P_OPC_W-1:0] OPC_JCCUI    = P_OPC_W'(8'h23);
  localparam logic [P_OPC_W-1:0] OPC_BCCSR    = P_OPC_W'(8'h24);
  localparam logic [P_OPC_W-1:0] OPC_BALSO    = P_OPC_W'(8'h25);
  localparam logic [P_OPC_W-1:0] OPC_SRADDSI  = P_OPC_W'(8'h26);
  localparam logic [P_OPC_W-1:0] OPC_SRLDSO   = P_OPC_W'(8'h27);
  localparam logic [P_OPC_W-1:0] OPC_SRJCCSO  = P_OPC_W'(8'h28);
  localparam logic [P_OPC_W-1:0] OPC_SRMOVAUR = P_OPC_W'(8'h29);

  localparam logic [13:0] STEP_14  = 14'(P_SSP_STEP);
  localparam logic [11:0] STEP_NEG = 12'(-P_SSP_STEP);
  localparam logic [9:0]  RET_ADJ  = 10'(P_RET_ADJ);

  typedef enum logic {ST_IDLE, ST_EXPAND} state_t;

  state_t                state_reg, state_next;
  logic [1:0]            idx_reg, idx_next;
  logic [P_OPC_W-1:0]    opc_reg, opc_next;
  logic [15:0]           pay_reg, pay_next;
  logic [P_ADDR_W-1:0]   pc_reg, pc_next;
  logic [P_DATA_W-1:0]   instr_reg, instr_next;
  logic                  busy_reg, busy_next;
  logic                  last_reg, last_next;
  logic [P_OPC_W-1:0]    dec_opc;
  logic [15:0]           dec_pay;
  logic [1:0]            step_idx;

  // Index of the final micro-op of a macro; 0 means a single micro-op.
  function automatic logic [1:0] last_idx(input logic [P_OPC_W-1:0] opc);
    case (opc)
      OPC_JSRUI, OPC_BSRSR, OPC_BSRSO: last_idx = 2'd3;
      OPC_RET:                         last_idx = 2'd2;
      OPC_KRET:                        last_idx = P_EN_KRET ? 2'd2 : 2'd0;
      default:                         last_idx = 2'd0;
    endcase
  endfunction

  function automatic logic [P_DATA_W-1:0] uop_gen(input logic [P_OPC_W-1:0] opc,
                                                   input logic [15:0] pay,
                                                   input logic [1:0] idx);
    logic [P_OPC_W-1:0] o;
    logic [15:0]        p;
    logic               is_ret;
    o = opc;
    p = pay;
    is_ret = (opc == OPC_RET) || (P_EN_KRET && (opc == OPC_KRET));
    if (opc == OPC_JSRUI || opc == OPC_BSRSR || opc == OPC_BSRSO) begin
      case (idx)
        2'd0: begin o = OPC_SRSUBSI; p = {`SR_IDX_SSP, STEP_14}; end
        2'd1: begin o = OPC_SRSTSO;  p = {`SR_IDX_SSP, `SR_IDX_LR, 12'd0}; end
        2'd2: begin o = OPC_SRMOVUR; p = {`SR_IDX_LR, `SR_IDX_PC, 12'd0}; end
        default: begin
          if (opc == OPC_JSRUI) begin
            o = OPC_JCCUI; p = {4'b0000, pay[11:0]};
          end else if (opc == OPC_BSRSR) begin
            o = OPC_BCCSR; p = {pay[15:12], 4'b0000, 8'd0};
          end else begin
            o = OPC_BALSO; p = pay;
          end
        end
      endcase
    end else if (is_ret) begin
      case (idx)
        2'd0:    begin o = OPC_SRADDSI; p = {`SR_IDX_SSP, STEP_14}; end
        2'd1:    begin o = OPC_SRLDSO;  p = {`SR_IDX_LR, `SR_IDX_SSP, STEP_NEG}; end
        default: begin o = OPC_SRJCCSO; p = {`SR_IDX_LR, 4'b0000, RET_ADJ}; end
      endcase
    end else if (opc == OPC_SETSSP) begin
      o = OPC_SRMOVAUR; p = {`SR_IDX_SSP, pay[15:14], 12'd0};
    end else if (opc == OPC_BTP) begin
      o = OPC_NOP; p = 16'd0;
    end
    uop_gen = {o, p};
  endfunction

  assign dec_opc  = iw_instr[P_DATA_W-1:16];
  assign dec_pay  = iw_instr[15:0];
  assign step_idx = idx_reg + 2'd1;

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    opc_next   = opc_reg;
    pay_next   = pay_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    busy_next  = busy_reg;
    last_next  = last_reg;
    if (iw_flush) begin
      // The PC of the aborted macro is kept; only the sequence is discarded.
      state_next = ST_IDLE;
      idx_next   = 2'd0;
      instr_next = {OPC_NOP, 16'd0};
      busy_next  = 1'b0;
      last_next  = 1'b1;
    end else if (!iw_stall) begin
      if (state_reg == ST_IDLE) begin
        opc_next   = dec_opc;
        pay_next   = dec_pay;
        pc_next    = iw_pc;
        idx_next   = 2'd0;
        instr_next = uop_gen(dec_opc, dec_pay, 2'd0);
        if (last_idx(dec_opc) != 2'd0) begin
          state_next = ST_EXPAND;
          busy_next  = 1'b1;
          last_next  = 1'b0;
        end else begin
          busy_next  = 1'b0;
          last_next  = 1'b1;
        end
      end else begin
        idx_next   = step_idx;
        instr_next = uop_gen(opc_reg, pay_reg, step_idx);
        if (step_idx == last_idx(opc_reg)) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          last_next  = 1'b1;
        end else begin
          busy_next  = 1'b1;
          last_next  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= 2'd0;
      opc_reg   <= '0;
      pay_reg   <= '0;
      pc_reg    <= '0;
      instr_reg <= {OPC_NOP, 16'd0};
      busy_reg  <= 1'b0;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      opc_reg   <= opc_next;
      pay_reg   <= pay_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      busy_reg  <= busy_next;
      last_reg  <= last_next;
    end
  end

  assign ow_pc       = pc_reg;
  assign ow_instr    = instr_reg;
  assign ow_busy     = busy_reg;
  assign ow_uop_idx  = idx_reg;
  assign ow_uop_last = last_reg;

endmodule

// File: tb/tb_xt_uop_seq.sv
// Bench for xt_uop_seq: directed scenarios plus randomized traffic checked
// against a macro-level sequence model, on three parameterizations.

module tb_xt_uop_seq;

  localparam logic [7:0] NOP = 8'h00, JSRUI = 8'h10, BSRSR = 8'h11, BSRSO = 8'h12,
                         RET = 8'h13, KRET = 8'h14, SETSSP = 8'h15, BTP = 8'h16,
                         SRSUBSI = 8'h20, SRSTSO = 8'h21, SRMOVUR = 8'h22, JCCUI = 8'h23,
                         BCCSR = 8'h24, BALSO = 8'h25, SRADDSI = 8'h26, SRLDSO = 8'h27,
                         SRJCCSO = 8'h28, SRMOVAUR = 8'h29;
  localparam logic [1:0] SSP = 2'd2, LR = 2'd1, PCR = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [47:0] pc = '0;
  logic [23:0] instr = '0;
  logic [47:0] o_pc    [3];
  logic [23:0] o_instr [3];
  logic        o_busy  [3];
  logic [1:0]  o_idx   [3];
  logic        o_last  [3];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xt_uop_seq dut0 (
    .iw_clk(clk), .iw_rst(rst), .iw_pc(pc), .iw_instr(instr), .iw_stall(stall),
    .iw_flush(flush), .ow_pc(o_pc[0]), .ow_instr(o_instr[0]), .ow_busy(o_busy[0]),
    .ow_uop_idx(o_idx[0]), .ow_uop_last(o_last[0]));

  xt_uop_seq #(.P_SSP_STEP(4), .P_RET_ADJ(2)) dut1 (
    .iw_clk(clk), .iw_rst(rst), .iw_pc(pc), .iw_instr(instr), .iw_stall(stall),
    .iw_flush(flush), .ow_pc(o_pc[1]), .ow_instr(o_instr[1]), .ow_busy(o_busy[1]),
    .ow_uop_idx(o_idx[1]), .ow_uop_last(o_last[1]));

  xt_uop_seq #(.P_EN_KRET(1'b0)) dut2 (
    .iw_clk(clk), .iw_rst(rst), .iw_pc(pc), .iw_instr(instr), .iw_stall(stall),
    .iw_flush(flush), .ow_pc(o_pc[2]), .ow_instr(o_instr[2]), .ow_busy(o_busy[2]),
    .ow_uop_idx(o_idx[2]), .ow_uop_last(o_last[2]));

  // Reference model (dut0 and dut1): the list of micro-ops of the current macro
  // and a cursor into it; a new macro is taken once the list is exhausted.
  int               step_k [2] = '{2, 4};
  int               adj_k  [2] = '{1, 2};
  int               m_n    [2];
  int               m_pos  [2];
  logic [3:0][23:0] m_u    [2];
  logic [75:0]      e_tup  [2];
  logic [47:0]      e_pc   [2];

  function automatic void expand(input logic [7:0] opc, input logic [15:0] pay,
                                 input int step, input int adj,
                                 output int n, output logic [3:0][23:0] u);
    logic [23:0] push_sp, save_lr, link;
    push_sp = {SRSUBSI, SSP, 14'(step)};
    save_lr = {SRSTSO, SSP, LR, 12'd0};
    link    = {SRMOVUR, LR, PCR, 12'd0};
    u = '0;
    n = 1;
    u[0] = {opc, pay};
    if (opc == JSRUI || opc == BSRSR || opc == BSRSO) begin
      n = 4;
      u[0] = push_sp; u[1] = save_lr; u[2] = link;
      if (opc == JSRUI)      u[3] = {JCCUI, 4'b0000, pay[11:0]};
      else if (opc == BSRSR) u[3] = {BCCSR, pay[15:12], 12'd0};
      else                   u[3] = {BALSO, pay};
    end else if (opc == RET || opc == KRET) begin
      n = 3;
      u[0] = {SRADDSI, SSP, 14'(step)};
      u[1] = {SRLDSO, LR, SSP, 12'(-step)};
      u[2] = {SRJCCSO, LR, 4'b0000, 10'(adj)};
    end else if (opc == SETSSP) begin
      u[0] = {SRMOVAUR, SSP, pay[15:14], 12'd0};
    end else if (opc == BTP) begin
      u[0] = {NOP, 16'd0};
    end
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_n[k] = 0; m_pos[k] = 0; e_pc[k] = '0;
        e_tup[k] = {24'd0, 48'd0, 1'b0, 2'd0, 1'b1};
      end else if (flush) begin
        m_n[k] = 0; m_pos[k] = 0;
        e_tup[k] = {24'd0, e_pc[k], 1'b0, 2'd0, 1'b1};
      end else if (!stall) begin
        if (m_pos[k] + 1 >= m_n[k]) begin
          expand(instr[23:16], instr[15:0], step_k[k], adj_k[k], m_n[k], m_u[k]);
          m_pos[k] = 0;
          e_pc[k] = pc;
        end else begin
          m_pos[k]++;
        end
        e_tup[k] = {m_u[k][m_pos[k]], e_pc[k], m_pos[k] != m_n[k] - 1, 2'(m_pos[k]),
                    m_pos[k] == m_n[k] - 1};
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [75:0] obs(input int d);
    return {o_instr[d], o_pc[d], o_busy[d], o_idx[d], o_last[d]};
  endfunction

  task automatic test_reset();
    logic [75:0] want;
    rst = 1'b1; stall = 1'b1; flush = 1'b1; instr = {JSRUI, 16'h1234}; pc = 48'h55;
    tick(); tick();
    want = {24'd0, 48'd0, 1'b0, 2'd0, 1'b1};
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (obs(d) !== want) begin
        n_fail++;
        $display("FAIL reset dut%0d: got %h want %h", d, obs(d), want);
      end
    end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_jsr();
    logic [23:0] ex [4];
    logic [75:0] want;
    ex[0] = {SRSUBSI, SSP, 14'd2};
    ex[1] = {SRSTSO, SSP, LR, 12'd0};
    ex[2] = {SRMOVUR, LR, PCR, 12'd0};
    ex[3] = {JCCUI, 4'b0000, 12'hABC};
    instr = {JSRUI, 4'h5, 12'hABC}; pc = 48'd100;
    for (int i = 0; i < 4; i++) begin
      tick();
      want = {ex[i], 48'd100, i < 3, 2'(i), i == 3};
      n_cmp++;
      if (obs(0) !== want) begin
        n_fail++;
        $display("FAIL jsr uop%0d: got %h want %h", i, obs(0), want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] ex [7];
    logic [47:0] ep [7];
    logic        eb [7];
    logic [75:0] want;
    int          ei [7] = '{0, 1, 2, 0, 1, 2, 3};
    ex[0] = {SRADDSI, SSP, 14'd2};
    ex[1] = {SRLDSO, LR, SSP, 12'hFFE};
    ex[2] = {SRJCCSO, LR, 4'b0000, 10'd1};
    ex[3] = {SRSUBSI, SSP, 14'd2};
    ex[4] = {SRSTSO, SSP, LR, 12'd0};
    ex[5] = {SRMOVUR, LR, PCR, 12'd0};
    ex[6] = {BALSO, 16'h00F0};
    for (int i = 0; i < 7; i++) begin
      ep[i] = (i < 3) ? 48'd200 : 48'd300;
      eb[i] = !(i == 2 || i == 6);
    end
    instr = {RET, 16'h0000}; pc = 48'd200;
    for (int i = 0; i < 7; i++) begin
      tick();
      want = {ex[i], ep[i], eb[i], 2'(ei[i]), !eb[i]};
      n_cmp++;
      if (obs(0) !== want) begin
        n_fail++;
        $display("FAIL back_to_back uop%0d: got %h want %h", i, obs(0), want);
      end
      if (i == 2) begin
        instr = {BSRSO, 16'h00F0}; pc = 48'd300;
      end
    end
  endtask

  task automatic test_params();
    logic [23:0] ex [3];
    logic [75:0] want;
    ex[0] = {SRADDSI, SSP, 14'd4};
    ex[1] = {SRLDSO, LR, SSP, 12'hFFC};
    ex[2] = {SRJCCSO, LR, 4'b0000, 10'd2};
    instr = {RET, 16'h0000}; pc = 48'd400;
    for (int i = 0; i < 3; i++) begin
      tick();
      want = {ex[i], 48'd400, i < 2, 2'(i), i == 2};
      n_cmp++;
      if (obs(1) !== want) begin
        n_fail++;
        $display("FAIL params uop%0d: got %h want %h", i, obs(1), want);
      end
    end
  endtask

  task automatic test_stall();
    logic [23:0] u1, u2, u3;
    logic [75:0] want;
    u1 = {SRSTSO, SSP, LR, 12'd0};
    u2 = {SRMOVUR, LR, PCR, 12'd0};
    u3 = {BCCSR, 4'h3, 4'b0000, 8'd0};
    instr = {BSRSR, 4'h3, 12'h000}; pc = 48'd500;
    tick(); tick();
    stall = 1'b1;
    instr = {JSRUI, 16'hFFFF};
    for (int i = 0; i < 3; i++) begin
      want = {u1, 48'd500, 1'b1, 2'd1, 1'b0};
      n_cmp++;
      if (obs(0) !== want) begin
        n_fail++;
        $display("FAIL stall hold%0d: got %h want %h", i, obs(0), want);
      end
      if (i < 2) tick();
    end
    stall = 1'b0;
    tick();
    want = {u2, 48'd500, 1'b1, 2'd2, 1'b0};
    n_cmp++;
    if (obs(0) !== want) begin
      n_fail++;
      $display("FAIL stall uop2: got %h want %h", obs(0), want);
    end
    tick();
    want = {u3, 48'd500, 1'b0, 2'd3, 1'b1};
    n_cmp++;
    if (obs(0) !== want) begin
      n_fail++;
      $display("FAIL stall uop3: got %h want %h", obs(0), want);
    end
  endtask

  task automatic test_flush();
    logic [75:0] want;
    instr = {JSRUI, 4'h1, 12'h055}; pc = 48'd600;
    tick(); tick(); tick();
    flush = 1'b1; stall = 1'b1;
    tick();
    want = {24'd0, 48'd600, 1'b0, 2'd0, 1'b1};
    n_cmp++;
    if (obs(0) !== want) begin
      n_fail++;
      $display("FAIL flush nop: got %h want %h", obs(0), want);
    end
    flush = 1'b0; stall = 1'b0;
    instr = {JCCUI, 4'hA, 12'h123}; pc = 48'd700;
    tick();
    want = {JCCUI, 4'hA, 12'h123, 48'd700, 1'b0, 2'd0, 1'b1};
    n_cmp++;
    if (obs(0) !== want) begin
      n_fail++;
      $display("FAIL flush passthrough: got %h want %h", obs(0), want);
    end
  endtask

  task automatic test_kret_and_reset();
    logic [75:0] want;
    instr = {KRET, 16'h1234}; pc = 48'd800;
    tick();
    want = {KRET, 16'h1234, 48'd800, 1'b0, 2'd0, 1'b1};
    n_cmp++;
    if (obs(2) !== want) begin
      n_fail++;
      $display("FAIL kret passthrough: got %h want %h", obs(2), want);
    end
    want = {SRADDSI, SSP, 14'd2, 48'd800, 1'b1, 2'd0, 1'b0};
    n_cmp++;
    if (obs(0) !== want) begin
      n_fail++;
      $display("FAIL kret expand: got %h want %h", obs(0), want);
    end
    tick(); tick();
    instr = {RET, 16'h0000}; pc = 48'd900;
    tick(); tick();
    rst = 1'b1;
    tick();
    want = {24'd0, 48'd0, 1'b0, 2'd0, 1'b1};
    n_cmp++;
    if (obs(0) !== want) begin
      n_fail++;
      $display("FAIL reset mid-ret: got %h want %h", obs(0), want);
    end
    rst = 1'b0;
    instr = {SETSSP, 2'b01, 14'd0}; pc = 48'd1000;
    tick();
    want = {SRMOVAUR, SSP, 2'b01, 12'd0, 48'd1000, 1'b0, 2'd0, 1'b1};
    n_cmp++;
    if (obs(0) !== want) begin
      n_fail++;
      $display("FAIL setssp after reset: got %h want %h", obs(0), want);
    end
  endtask

  task automatic test_random();
    logic [7:0] opc;
    for (int c = 0; c < 500; c++) begin
      if (!o_busy[0]) begin
        case ($urandom % 10)
          0: opc = JSRUI;  1: opc = BSRSR;  2: opc = BSRSO; 3: opc = RET;
          4: opc = KRET;   5: opc = SETSSP; 6: opc = BTP;   7: opc = JCCUI;
          8: opc = NOP;    default: opc = 8'($urandom);
        endcase
        instr = {opc, 16'($urandom)};
        pc = {16'($urandom), 32'($urandom)};
      end
      rst   = ($urandom % 60) == 0;
      flush = ($urandom % 25) == 0;
      stall = ($urandom % 6) == 0;
      tick();
      for (int k = 0; k < 2; k++) begin
        n_cmp++;
        if (obs(k) !== e_tup[k]) begin
          n_fail++;
          $display("FAIL random cyc%0d dut%0d: got %h want %h", c, k, obs(k), e_tup[k]);
        end
      end
    end
    rst = 1'b0; flush = 1'b0; stall = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_jsr();
    test_back_to_back();
    test_params();
    test_stall();
    test_flush();
    test_kret_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
